// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// mux4_rr_arbiter
// Round-robin arbiter driving a shared 4:1 mux, with abort and watchdog release.
// Revision: 1.0
// ============================================================================
module mux4_rr_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // With TIMEOUT=0 this wraps to all-ones, which is where cnt saturates.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic             WDOG_EN  = (TIMEOUT != 0);

    logic [0:0]       state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;

    logic [3:0] rot;
    logic [1:0] off;
    logic [1:0] winner;
    logic       wdog_hit;
    logic       rel_any;

    // Rotate requests so bit 0 is the current highest-priority requester.
    assign rot = 4'({req, req} >> ptr);

    always_comb begin
        off = 2'd0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
    end

    assign winner   = ptr + off;
    assign wdog_hit = WDOG_EN && (cnt == CNT_LAST);
    assign rel_any  = done || !req[sel] || wdog_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            sel     <= 2'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            ptr     <= 2'd0;
            cnt     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= BUSY;
                        gnt   <= 4'b0001 << winner;
                        sel   <= winner;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (rel_any) begin
                        state   <= IDLE;
                        gnt     <= 4'b0000;
                        busy    <= 1'b0;
                        ptr     <= sel + 2'd1;
                        // Pulse only when the watchdog alone caused the release.
                        timeout <= !done && req[sel] && wdog_hit;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
